// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect inputs, instruction-memory port and IF/ID outputs.
// master = fetch_stage, slave = environment (memory, hazard unit, decode).
interface fetch_stage_if;
   localparam int unsigned XLEN = 32;

   logic            stall;
   logic            br_taken;
   logic [XLEN-1:0] br_target;
   logic            imem_en;
   logic [XLEN-1:0] imem_addr;
   logic [XLEN-1:0] imem_rdata;
   logic            id_valid;
   logic [XLEN-1:0] id_instr;
   logic [XLEN-1:0] id_pc;

   modport master (
      input  stall, br_taken, br_target, imem_rdata,
      output imem_en, imem_addr, id_valid, id_instr, id_pc
   );

   modport slave (
      output stall, br_taken, br_target, imem_rdata,
      input  imem_en, imem_addr, id_valid, id_instr, id_pc
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, in-flight request tag, IF/ID register and redirect flush.
// Optional macro FETCH_SKID_EN adds a skid register so memory need not hold rdata while disabled.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic          clk,
   input  logic          reset,
   fetch_stage_if.master fif
);
   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_RUN   = 2'd1,
      S_STALL = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            f_valid_q, f_valid_d;
   logic [XLEN-1:0] f_pc_q, f_pc_d;
   logic            id_valid_q, id_valid_d;
   logic [XLEN-1:0] id_instr_q, id_instr_d;
   logic [XLEN-1:0] id_pc_q, id_pc_d;
   logic [XLEN-1:0] load_instr_c;
   logic            hold_c;

   assign hold_c = fif.stall & ~fif.br_taken;

`ifdef FETCH_SKID_EN
   logic [XLEN-1:0] skid_q, skid_d;
   logic            held_q, held_d;

   // rdata is only fresh on the first held cycle; afterwards the memory may drift
   always_comb begin
      skid_d = skid_q;
      held_d = hold_c;
      if (hold_c && !held_q) begin
         skid_d = fif.imem_rdata;
      end
   end

   assign load_instr_c = held_q ? skid_q : fif.imem_rdata;
`else
   assign load_instr_c = fif.imem_rdata;
`endif

   // Next-state: redirect beats stall, stall freezes everything, otherwise issue and advance
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      f_valid_d  = f_valid_q;
      f_pc_d     = f_pc_q;
      id_valid_d = id_valid_q;
      id_instr_d = id_instr_q;
      id_pc_d    = id_pc_q;

      if (fif.br_taken) begin
         pc_d       = fif.br_target;
         f_valid_d  = 1'b0;
         id_valid_d = 1'b0;
         state_d    = S_FILL;
      end else if (fif.stall) begin
         case (state_q)
            S_RUN:   state_d = S_STALL;
            S_STALL: state_d = S_STALL;
            default: state_d = S_FILL;
         endcase
      end else begin
         pc_d       = pc_q + XLEN'(1);
         f_valid_d  = 1'b1;
         f_pc_d     = pc_q;
         id_valid_d = f_valid_q;
         id_instr_d = load_instr_c;
         id_pc_d    = f_pc_q;
         case (state_q)
            S_FILL:  state_d = f_valid_d ? S_RUN : S_FILL;
            default: state_d = S_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_FILL;
         pc_q       <= RESET_PC;
         f_valid_q  <= 1'b0;
         f_pc_q     <= '0;
         id_valid_q <= 1'b0;
         id_instr_q <= '0;
         id_pc_q    <= '0;
`ifdef FETCH_SKID_EN
         skid_q     <= '0;
         held_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         f_valid_q  <= f_valid_d;
         f_pc_q     <= f_pc_d;
         id_valid_q <= id_valid_d;
         id_instr_q <= id_instr_d;
         id_pc_q    <= id_pc_d;
`ifdef FETCH_SKID_EN
         skid_q     <= skid_d;
         held_q     <= held_d;
`endif
      end
   end

   // Request enable drops combinationally with reset so nothing is issued while held
   assign fif.imem_en   = reset & ~fif.stall;
   assign fif.imem_addr = pc_q;
   assign fif.id_valid  = id_valid_q;
   assign fif.id_instr  = id_instr_q;
   assign fif.id_pc     = id_pc_q;

endmodule
